// File: rtl/det_evt_pkg.sv
// Shared defaults and helpers for the detector event logger.
package det_evt_pkg;

  localparam int DET_TS_W_DEF    = 16;
  localparam int DET_DEPTH_DEF   = 4;
  localparam int DET_CNT_W_DEF   = 8;
  localparam int DET_HOLDOFF_DEF = 8;

  // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/det_evt_fifo.sv
// Pointer FIFO with an extra wrap bit; head is read combinationally and forced to zero when empty.
module det_evt_fifo
  import det_evt_pkg::*;
#(
  parameter int W     = DET_TS_W_DEF,
  parameter int DEPTH = DET_DEPTH_DEF
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is data only: it needs no reset because the head is masked while empty.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == PW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/det_event_logger.sv
// Turns detector rising edges into timestamped events queued for a valid/ready consumer.
// Optional re-trigger holdoff window is built when DET_EVT_HOLDOFF_EN is defined.
module det_event_logger
  import det_evt_pkg::*;
#(
  parameter int TS_W    = DET_TS_W_DEF,
  parameter int DEPTH   = DET_DEPTH_DEF,
  parameter int CNT_W   = DET_CNT_W_DEF,
  parameter int HOLDOFF = DET_HOLDOFF_DEF
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      det_in,
  input  logic                      clr,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [TS_W-1:0]           evt_ts,
  output logic [CNT_W-1:0]          evt_count,
  output logic                      ovf,
  output logic [lvl_w(DEPTH)-1:0]   fifo_level
);

  logic [TS_W-1:0] ts;
  logic            det_d;
  logic            rise;
  logic            trig;
  logic            pop;
  logic            push;
  logic            drop;
  logic            full;
  logic            empty;

  // det_d keeps sampling through clr so a level held across it yields no new edge.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      ts    <= '0;
      det_d <= 1'b0;
    end else begin
      ts    <= clr ? '0 : ts + TS_W'(1);
      det_d <= det_in;
    end
  end

  assign rise = det_in & ~det_d;

`ifdef DET_EVT_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  logic [HW-1:0] hold_cnt;

  // Any recognised event, accepted or dropped, reopens the window.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset)             hold_cnt <= '0;
    else if (clr)           hold_cnt <= '0;
    else if (trig)          hold_cnt <= HW'(HOLDOFF);
    else if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
  end

  assign trig = rise & (hold_cnt == '0);
`else
  logic unused_holdoff;
  assign unused_holdoff = (HOLDOFF != 0);
  assign trig = rise;
`endif

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign pop  = evt_valid & evt_ready & ~clr;
  assign push = trig & ~clr & (~full | pop);
  assign drop = trig & ~clr & full & ~pop;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else begin
      if (push && (evt_count != '1)) evt_count <= evt_count + CNT_W'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  det_evt_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .din     (ts),
    .head    (evt_ts),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign evt_valid = ~empty;

endmodule
